// File: rtl/bsg_mesh_router_buffered.sv
`timescale 1ns/1ps
// ============================================================================
// bsg_mesh_router_buffered
// ----------------------------------------------------------------------------
// Five-port 2D-mesh router node (P=0, W=1, E=2, N=3, S=4) for the manycore
// fabric. Every input port has a small FIFO. The head packet of each FIFO is
// routed by dimension order (XY or YX). Each output has a round-robin arbiter
// that holds its grant until the downstream handshake completes. Directions
// can be stubbed off. A packet whose route points at a stubbed output is
// thrown away as soon as it reaches its FIFO head, and drop_o flags it.
//
// Optional build feature (macro BSG_MESH_ROUTER_STATS_EN):
//   Adds stat_count_o, one saturating 32-bit handshake counter per output.
//
// Parameters:
//   width_p         total packet width; [x_cord_width_p-1:0] = dest x,
//                   the next y_cord_width_p bits = dest y
//   x_cord_width_p  x coordinate width
//   y_cord_width_p  y coordinate width
//   fifo_els_p      per-input FIFO depth (power of 2, >= 2)
//   yx_mode_p       0: route X then Y, 1: route Y then X
//   stub_p          bit d = 1 stubs direction d (P can never be stubbed)
//
// Ports:
//   clk_i          clock
//   reset_n_i      asynchronous active-low reset
//   my_x_i/my_y_i  this node's coordinates
//   link_v_i       per-direction input valid
//   link_data_i    per-direction input packet, slice d = [d*width_p +: width_p]
//   link_ready_o   per-direction input ready (FIFO not full)
//   link_v_o       per-direction output valid
//   link_data_o    per-direction output packet
//   link_ready_i   per-direction downstream ready
//   drop_o         per-input pulse when its head packet is dropped
//   stat_count_o   (STATS build only) per-output handshake counters, 5 x 32
// ============================================================================
module bsg_mesh_router_buffered #(
    parameter int         width_p        = 64,
    parameter int         x_cord_width_p = 4,
    parameter int         y_cord_width_p = 4,
    parameter int         fifo_els_p     = 4,
    parameter int         yx_mode_p      = 0,
    parameter logic [4:0] stub_p         = 5'b00000
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic [x_cord_width_p-1:0]   my_x_i,
    input  logic [y_cord_width_p-1:0]   my_y_i,
    input  logic [4:0]                  link_v_i,
    input  logic [5*width_p-1:0]        link_data_i,
    output logic [4:0]                  link_ready_o,
    output logic [4:0]                  link_v_o,
    output logic [5*width_p-1:0]        link_data_o,
    input  logic [4:0]                  link_ready_i,
    output logic [4:0]                  drop_o
`ifdef BSG_MESH_ROUTER_STATS_EN
    ,
    output logic [5*32-1:0]             stat_count_o
`endif
);

    typedef enum logic [2:0] {
        DIR_P = 3'd0,
        DIR_W = 3'd1,
        DIR_E = 3'd2,
        DIR_N = 3'd3,
        DIR_S = 3'd4
    } dir_e;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    localparam int                ptr_w_lp     = $clog2(fifo_els_p);
    localparam int                cnt_w_lp     = ptr_w_lp + 1;
    localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(fifo_els_p);
    // The processor port can never be stubbed, whatever stub_p says.
    localparam logic [4:0]        stub_mask_lp = stub_p & 5'b11110;

    // ------------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------------
    logic [width_p-1:0]   fifo_mem_r    [5][fifo_els_p];
    logic [ptr_w_lp-1:0]  rd_ptr_r      [5];
    logic [ptr_w_lp-1:0]  wr_ptr_r      [5];
    logic [cnt_w_lp-1:0]  count_r       [5];

    arb_state_e           arb_state_r   [5];
    logic [2:0]           held_winner_r [5];
    logic [2:0]           last_winner_r [5];

    // ------------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------------
    logic [4:0]           fifo_empty;
    logic [4:0]           fifo_full;
    logic [4:0]           enq;
    logic [4:0]           deq;
    logic [4:0]           drop;
    logic [width_p-1:0]   head_data     [5];
    dir_e                 head_route    [5];
    logic [4:0]           req           [5];
    logic [2:0]           winner        [5];
    logic [4:0]           grant_v;
    logic [4:0]           hs;

    // Dimension-order routing of one packet. Comparisons are unsigned at the
    // full coordinate width. The first dimension that differs decides the hop.
    function automatic dir_e route_f(
        input logic [width_p-1:0]        pkt,
        input logic [x_cord_width_p-1:0] my_x,
        input logic [y_cord_width_p-1:0] my_y
    );
        logic [x_cord_width_p-1:0] dx;
        logic [y_cord_width_p-1:0] dy;
        dir_e                      x_dir;
        dir_e                      y_dir;
        dx    = pkt[x_cord_width_p-1:0];
        dy    = pkt[x_cord_width_p +: y_cord_width_p];
        x_dir = (dx > my_x) ? DIR_E : ((dx < my_x) ? DIR_W : DIR_P);
        y_dir = (dy > my_y) ? DIR_S : ((dy < my_y) ? DIR_N : DIR_P);
        if (yx_mode_p != 0) begin
            return (y_dir != DIR_P) ? y_dir : x_dir;
        end
        return (x_dir != DIR_P) ? x_dir : y_dir;
    endfunction

    // Round-robin pick: scan from last+1 upward with wrap at 5. Bit 3 of the
    // result is the "found" flag and bits 2:0 give the chosen input. The scan
    // runs from the far end back toward last+1, so the nearest requester
    // writes the result last and wins.
    function automatic logic [3:0] rr_pick_f(
        input logic [4:0] req_vec,
        input logic [2:0] last
    );
        logic [3:0] result;
        logic [2:0] idx;
        int         sum;
        result = {1'b0, last};
        for (int k = 5; k >= 1; k--) begin
            sum = int'(last) + k;
            if (sum >= 5) begin
                sum = sum - 5;
            end
            idx = 3'(sum);
            if (req_vec[idx]) begin
                result = {1'b1, idx};
            end
        end
        return result;
    endfunction

    // FIFO status, head routing, drop detection and per-output request
    // vectors. All of them come from registered FIFO state only.
    always_comb begin
        for (int d = 0; d < 5; d++) begin
            fifo_empty[d] = (count_r[d] == '0);
            fifo_full[d]  = (count_r[d] == full_cnt_lp);
            head_data[d]  = fifo_mem_r[d][rd_ptr_r[d]];
            head_route[d] = route_f(head_data[d], my_x_i, my_y_i);
            drop[d]       = !fifo_empty[d] && stub_mask_lp[head_route[d]];
            enq[d]        = link_v_i[d] && !fifo_full[d] && !stub_mask_lp[d];
        end
        for (int o = 0; o < 5; o++) begin
            req[o] = '0;
            for (int d = 0; d < 5; d++) begin
                req[o][d] = !fifo_empty[d] && (int'(head_route[d]) == o)
                            && !stub_mask_lp[o];
            end
        end
    end

    // Output arbitration. A locked output keeps its winner, so its data stays
    // stable until the handshake. An idle output grants in the same cycle a
    // request appears, which lets a packet reach an output one cycle after
    // it was enqueued.
    always_comb begin
        logic [3:0] pick;
        pick = '0;
        for (int o = 0; o < 5; o++) begin
            pick = rr_pick_f(req[o], last_winner_r[o]);
            if (arb_state_r[o] == ARB_LOCKED) begin
                winner[o]  = held_winner_r[o];
                grant_v[o] = 1'b1;
            end else begin
                winner[o]  = pick[2:0];
                grant_v[o] = pick[3];
            end
            hs[o] = grant_v[o] && link_ready_i[o];
        end
    end

    // Dequeue on an output handshake or a drop. Each head requests exactly
    // one output, so no input can be dequeued twice in one cycle.
    always_comb begin
        deq = drop;
        for (int o = 0; o < 5; o++) begin
            if (hs[o]) begin
                deq[winner[o]] = 1'b1;
            end
        end
    end

    // Output drive. A stubbed input always reports ready and never fills.
    always_comb begin
        link_data_o = '0;
        for (int o = 0; o < 5; o++) begin
            if (grant_v[o]) begin
                link_data_o[o*width_p +: width_p] = head_data[winner[o]];
            end
        end
        link_v_o     = grant_v;
        link_ready_o = stub_mask_lp | ~fifo_full;
        drop_o       = drop;
    end

    // Payload storage. This needs no reset, because count_r alone decides
    // which entries are meaningful.
    always_ff @(posedge clk_i) begin
        for (int d = 0; d < 5; d++) begin
            if (enq[d]) begin
                fifo_mem_r[d][wr_ptr_r[d]] <= link_data_i[d*width_p +: width_p];
            end
        end
    end

    // FIFO pointers and occupancy. Enqueue and dequeue in the same cycle
    // leave the count unchanged. A full FIFO cannot enqueue because its ready
    // is low.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int d = 0; d < 5; d++) begin
                rd_ptr_r[d] <= '0;
                wr_ptr_r[d] <= '0;
                count_r[d]  <= '0;
            end
        end else begin
            for (int d = 0; d < 5; d++) begin
                if (enq[d]) begin
                    wr_ptr_r[d] <= wr_ptr_r[d] + ptr_w_lp'(1);
                end
                if (deq[d]) begin
                    rd_ptr_r[d] <= rd_ptr_r[d] + ptr_w_lp'(1);
                end
                case ({enq[d], deq[d]})
                    2'b10:   count_r[d] <= count_r[d] + cnt_w_lp'(1);
                    2'b01:   count_r[d] <= count_r[d] - cnt_w_lp'(1);
                    default: count_r[d] <= count_r[d];
                endcase
            end
        end
    end

    // Per-output grant lock and round-robin pointer. A grant without a
    // handshake locks the output. A handshake releases it and moves the
    // priority past the winner.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int o = 0; o < 5; o++) begin
                arb_state_r[o]   <= ARB_IDLE;
                held_winner_r[o] <= 3'(DIR_P);
                last_winner_r[o] <= 3'(DIR_P);
            end
        end else begin
            for (int o = 0; o < 5; o++) begin
                if (hs[o]) begin
                    last_winner_r[o] <= winner[o];
                    arb_state_r[o]   <= ARB_IDLE;
                end else if (grant_v[o]) begin
                    held_winner_r[o] <= winner[o];
                    arb_state_r[o]   <= ARB_LOCKED;
                end
            end
        end
    end

`ifdef BSG_MESH_ROUTER_STATS_EN
    logic [31:0] stat_r [5];

    // Saturating handshake counters. Stubbed outputs never handshake, so
    // their counters stay at zero.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int o = 0; o < 5; o++) begin
                stat_r[o] <= '0;
            end
        end else begin
            for (int o = 0; o < 5; o++) begin
                if (hs[o] && (stat_r[o] != 32'hFFFF_FFFF)) begin
                    stat_r[o] <= stat_r[o] + 32'd1;
                end
            end
        end
    end

    always_comb begin
        stat_count_o = '0;
        for (int o = 0; o < 5; o++) begin
            stat_count_o[o*32 +: 32] = stat_r[o];
        end
    end
`endif

endmodule
